// File: rtl/key_counter_pkg.sv
// Shared constants and elaboration helpers for the key counter display:
// 7-segment pattern table, BCD conversion and ceil-log2.
package key_counter_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low patterns for digits 0..9, bit7 = dp (off), bits6..0 = g..a.
    localparam logic [7:0] SEG_TABLE [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    // Ceil-log2, never below 1 so it can size any register directly.
    function automatic int clog2(input int unsigned n);
        int          r;
        int unsigned v;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Eight BCD digits of n, digit 0 in bits 3..0.
    function automatic logic [31:0] to_bcd(input int unsigned n);
        logic [31:0] r;
        int unsigned v;
        r = '0;
        v = n;
        for (int i = 0; i < 8; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        return (d <= 4'd9) ? SEG_TABLE[d] : SEG_BLANK;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button path: 2-flop synchroniser, stability debouncer and a
// single-cycle pulse on each accepted press (high-to-low of the active-low key).
module key_debounce
    import key_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press_pulse
);

    localparam int               CNT_W    = clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [1:0]       sync_fill;
    logic             level;
    logic             level_d;
    logic             armed;
    logic [CNT_W-1:0] cnt;

    // armed stays low after reset until a genuinely released key is seen, so a
    // press that straddles reset never produces a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1      <= 1'b1;
            sync_2      <= 1'b1;
            sync_fill   <= '0;
            level       <= 1'b1;
            level_d     <= 1'b1;
            armed       <= 1'b0;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge value of its neighbours, giving a true shift chain.
            sync_1    <= key_n;
            sync_2    <= sync_1;
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && sync_2)
                armed <= 1'b1;

            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            level_d     <= level;
            press_pulse <= armed & level_d & ~level;
        end
    end

endmodule

// File: rtl/key_counter_display.sv
// Up/down press counter modulo MODULO, kept in binary and BCD, driving a
// time-multiplexed common-anode 7-segment display with leading-zero blanking.
module key_counter_display
    import key_counter_pkg::*;
#(
    parameter  int DIGITS          = 2,
    parameter  int MODULO          = 20,
    parameter  int DEBOUNCE_CYCLES = 1000000,
    parameter  int SCAN_DIV        = 8192,
    parameter  int BLANK_LZ        = 1,
    localparam int CW              = clog2(MODULO)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_up,
    input  logic              key_down,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] sel,
    output logic [CW-1:0]     value,
    output logic              wrap
);

    localparam int               SW         = clog2(SCAN_DIV);
    localparam int               IW         = clog2(DIGITS);
    localparam logic [SW-1:0]    SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]    IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [CW-1:0]    VALUE_MAX  = CW'(MODULO - 1);
    localparam logic [31:0]      MAX_BCD_ALL = to_bcd(MODULO - 1);

    logic              up_pulse;
    logic              down_pulse;
    logic [3:0]        digit     [DIGITS];
    logic [3:0]        digit_inc [DIGITS];
    logic [3:0]        digit_dec [DIGITS];
    logic [DIGITS-1:0] blank;
    logic [SW-1:0]     scan_cnt;
    logic [IW-1:0]     idx;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_up),
        .press_pulse (up_pulse)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_down),
        .press_pulse (down_pulse)
    );

    // Ripple BCD increment/decrement; the wrap cases are handled separately.
    always_comb begin
        logic carry;
        logic borrow;
        // NOTE: blocking assignments and a default for every output before the
        // loop, so carry/borrow ripple in order and no latch is inferred.
        carry  = 1'b1;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            digit_inc[i] = digit[i];
            digit_dec[i] = digit[i];
            if (carry) begin
                if (digit[i] == 4'd9) begin
                    digit_inc[i] = 4'd0;
                end else begin
                    digit_inc[i] = digit[i] + 4'd1;
                    carry        = 1'b0;
                end
            end
            if (borrow) begin
                if (digit[i] == 4'd0) begin
                    digit_dec[i] = 4'd9;
                end else begin
                    digit_dec[i] = digit[i] - 4'd1;
                    borrow       = 1'b0;
                end
            end
        end
    end

    // Digit i > 0 is blank when it and every higher digit are zero.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        blank    = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run && (digit[i] == 4'd0);
            blank[i] = (BLANK_LZ != 0) && zero_run;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
            wrap  <= 1'b0;
            // NOTE: the digit array is a handful of flops, not a RAM, so it
            // is reset with the rest of the state.
            for (int i = 0; i < DIGITS; i++)
                digit[i] <= 4'd0;
        end else begin
            wrap <= 1'b0;
            if (up_pulse && !down_pulse) begin
                if (value == VALUE_MAX) begin
                    value <= '0;
                    wrap  <= 1'b1;
                    for (int i = 0; i < DIGITS; i++)
                        digit[i] <= 4'd0;
                end else begin
                    value <= value + 1'b1;
                    digit <= digit_inc;
                end
            end else if (down_pulse && !up_pulse) begin
                if (value == '0) begin
                    value <= VALUE_MAX;
                    wrap  <= 1'b1;
                    for (int i = 0; i < DIGITS; i++)
                        digit[i] <= MAX_BCD_ALL[i*4 +: 4];
                end else begin
                    value <= value - 1'b1;
                    digit <= digit_dec;
                end
            end
        end
    end

    // Scan divider, digit index and registered display drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            seg      <= SEG_BLANK;
            sel      <= '1;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            sel <= ~(DIGITS'(1) << idx);
            seg <= blank[idx] ? SEG_BLANK : seg_of(digit[idx]);
        end
    end

endmodule

// File: tb/tb_key_counter_display.sv
// Directed bench for key_counter_display: a 2-digit modulo-20 instance and a
// 3-digit modulo-250 instance, both with short debounce and scan periods.
module tb_key_counter_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_up_a = 1'b1, key_down_a = 1'b1;
    logic       key_up_b = 1'b1, key_down_b = 1'b1;
    logic [7:0] seg_a, seg_b;
    logic [1:0] sel_a;
    logic [2:0] sel_b;
    logic [4:0] value_a;
    logic [7:0] value_b;
    logic       wrap_a, wrap_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    key_counter_display #(
        .DIGITS(2), .MODULO(20), .DEBOUNCE_CYCLES(4), .SCAN_DIV(4), .BLANK_LZ(1)
    ) dut_a (
        .clk(clk), .rst(rst), .key_up(key_up_a), .key_down(key_down_a),
        .seg(seg_a), .sel(sel_a), .value(value_a), .wrap(wrap_a)
    );

    key_counter_display #(
        .DIGITS(3), .MODULO(250), .DEBOUNCE_CYCLES(4), .SCAN_DIV(4), .BLANK_LZ(1)
    ) dut_b (
        .clk(clk), .rst(rst), .key_up(key_up_b), .key_down(key_down_b),
        .seg(seg_b), .sel(sel_b), .value(value_b), .wrap(wrap_b)
    );

    // Leaves the caller on the falling edge just after the last reset edge.
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One press/release on dut_a; returns how many cycles wrap was high.
    task automatic press_a(input logic up, input logic dn, output int wraps);
        wraps = 0;
        @(negedge clk);
        key_up_a   = ~up;
        key_down_a = ~dn;
        repeat (12) begin
            @(negedge clk);
            if (wrap_a) wraps++;
        end
        key_up_a   = 1'b1;
        key_down_a = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (wrap_a) wraps++;
        end
    endtask

    task automatic check_digit_a(input int i, input logic [7:0] exp, input string nm);
        logic [1:0] want;
        bit         found;
        want  = ~(2'b01 << i);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (sel_a === want) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s: sel never reached %b (last %b)", nm, want, sel_a);
        end else if (seg_a !== exp) begin
            n_fail++;
            $display("FAIL %s: seg got %h expected %h", nm, seg_a, exp);
        end
    endtask

    task automatic check_digit_b(input int i, input logic [7:0] exp, input string nm);
        logic [2:0] want;
        bit         found;
        want  = ~(3'b001 << i);
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk);
            if (sel_b === want) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s: sel never reached %b (last %b)", nm, want, sel_b);
        end else if (seg_b !== exp) begin
            n_fail++;
            $display("FAIL %s: seg got %h expected %h", nm, seg_b, exp);
        end
    endtask

    task automatic test_reset();
        logic [1:0] exp_sel;
        logic [7:0] exp_seg;
        apply_reset();
        n_checks++;
        if (seg_a !== 8'hFF || sel_a !== 2'b11 || value_a !== 5'd0 || wrap_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: seg=%h sel=%b value=%0d wrap=%b expected FF 11 0 0",
                     seg_a, sel_a, value_a, wrap_a);
        end
        n_checks++;
        if (seg_b !== 8'hFF || sel_b !== 3'b111 || value_b !== 8'd0 || wrap_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b: seg=%h sel=%b value=%0d wrap=%b expected FF 111 0 0",
                     seg_b, sel_b, value_b, wrap_b);
        end
        // Digit 0 selected for 4 cycles, then digit 1 (blank) for 4, repeating.
        for (int k = 1; k <= 48; k++) begin
            @(negedge clk);
            exp_sel = (((k - 1) / 4) % 2 == 0) ? 2'b10 : 2'b01;
            exp_seg = (exp_sel == 2'b10) ? 8'hC0 : 8'hFF;
            n_checks++;
            if (sel_a !== exp_sel || seg_a !== exp_seg || value_a !== 5'd0) begin
                n_fail++;
                $display("FAIL idle_scan cycle %0d: sel=%b seg=%h value=%0d expected %b %h 0",
                         k, sel_a, seg_a, value_a, exp_sel, exp_seg);
            end
        end
    endtask

    task automatic test_debounce_glitch();
        bit early;
        int wraps;
        apply_reset();
        idle(5);
        key_up_a = 1'b0; idle(1);
        key_up_a = 1'b1; idle(2);
        repeat (3) begin
            key_up_a = 1'b0; idle(3);
            key_up_a = 1'b1; idle(1);
        end
        idle(2);
        n_checks++;
        if (value_a !== 5'd0) begin
            n_fail++;
            $display("FAIL glitch_reject: value got %0d expected 0", value_a);
        end
        // Stable hold from edge E: pulse in E+6, counter visible after E+7.
        key_up_a = 1'b0;
        early    = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (value_a !== 5'd0) early = 1'b1;
        end
        n_checks++;
        if (early) begin
            n_fail++;
            $display("FAIL latency_early: value changed before E+7 (got %0d expected 0)", value_a);
        end
        @(negedge clk);
        n_checks++;
        if (value_a !== 5'd1) begin
            n_fail++;
            $display("FAIL latency_value: value got %0d expected 1 after E+7", value_a);
        end
        idle(12);
        key_up_a = 1'b1;
        wraps = 0;
        repeat (12) begin
            @(negedge clk);
            if (wrap_a) wraps++;
        end
        n_checks++;
        if (value_a !== 5'd1 || wraps != 0) begin
            n_fail++;
            $display("FAIL single_pulse: value=%0d wraps=%0d expected 1 0", value_a, wraps);
        end
        check_digit_a(0, 8'hF9, "glitch_digit0");
        check_digit_a(1, 8'hFF, "glitch_digit1_blank");
    endtask

    task automatic test_up_wrap();
        int w;
        int total;
        apply_reset();
        idle(5);
        total = 0;
        for (int p = 0; p < 19; p++) begin
            press_a(1'b1, 1'b0, w);
            total += w;
        end
        n_checks++;
        if (value_a !== 5'd19 || total != 0) begin
            n_fail++;
            $display("FAIL up_19: value=%0d wraps=%0d expected 19 0", value_a, total);
        end
        check_digit_a(1, 8'hF9, "up19_tens");
        check_digit_a(0, 8'h90, "up19_units");
        press_a(1'b1, 1'b0, w);
        n_checks++;
        if (value_a !== 5'd0 || w != 1) begin
            n_fail++;
            $display("FAIL up_wrap: value=%0d wrap_cycles=%0d expected 0 1", value_a, w);
        end
        check_digit_a(0, 8'hC0, "up_wrap_units");
        check_digit_a(1, 8'hFF, "up_wrap_tens_blank");
    endtask

    task automatic test_down_wrap();
        int w;
        apply_reset();
        idle(5);
        press_a(1'b0, 1'b1, w);
        n_checks++;
        if (value_a !== 5'd19 || w != 1) begin
            n_fail++;
            $display("FAIL down_wrap: value=%0d wrap_cycles=%0d expected 19 1", value_a, w);
        end
        press_a(1'b0, 1'b1, w);
        n_checks++;
        if (value_a !== 5'd18 || w != 0) begin
            n_fail++;
            $display("FAIL down_step: value=%0d wrap_cycles=%0d expected 18 0", value_a, w);
        end
        check_digit_a(1, 8'hF9, "down18_tens");
        check_digit_a(0, 8'h80, "down18_units");
    endtask

    task automatic test_back_to_back();
        int w;
        apply_reset();
        idle(5);
        press_a(1'b1, 1'b0, w);
        press_a(1'b1, 1'b1, w);
        n_checks++;
        if (value_a !== 5'd1 || w != 0) begin
            n_fail++;
            $display("FAIL both_keys: value=%0d wrap_cycles=%0d expected 1 0", value_a, w);
        end
        // Both at zero must not take the down-wrap path either.
        press_a(1'b0, 1'b1, w);
        press_a(1'b1, 1'b1, w);
        n_checks++;
        if (value_a !== 5'd0 || w != 0) begin
            n_fail++;
            $display("FAIL both_keys_zero: value=%0d wrap_cycles=%0d expected 0 0", value_a, w);
        end
    endtask

    task automatic test_reset_mid_press();
        int w;
        apply_reset();
        idle(5);
        key_up_a = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(20);
        key_up_a = 1'b1;
        w = 0;
        repeat (12) begin
            @(negedge clk);
            if (wrap_a) w++;
        end
        n_checks++;
        if (value_a !== 5'd0 || w != 0) begin
            n_fail++;
            $display("FAIL reset_mid_press: value=%0d wraps=%0d expected 0 0", value_a, w);
        end
        press_a(1'b1, 1'b0, w);
        n_checks++;
        if (value_a !== 5'd1) begin
            n_fail++;
            $display("FAIL fresh_press_after_reset: value got %0d expected 1", value_a);
        end
    endtask

    task automatic test_wide();
        int w;
        apply_reset();
        idle(5);
        w = 0;
        @(negedge clk);
        key_down_b = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (wrap_b) w++;
        end
        key_down_b = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (wrap_b) w++;
        end
        n_checks++;
        if (value_b !== 8'd249 || w != 1) begin
            n_fail++;
            $display("FAIL wide_down_wrap: value=%0d wrap_cycles=%0d expected 249 1", value_b, w);
        end
        check_digit_b(2, 8'hA4, "wide_hundreds");
        check_digit_b(1, 8'h99, "wide_tens");
        check_digit_b(0, 8'h90, "wide_units");
    endtask

    initial begin
        test_reset();
        test_debounce_glitch();
        test_up_wrap();
        test_down_wrap();
        test_back_to_back();
        test_reset_mid_press();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
